// File: rtl/mode7_affine_stream_pkg.sv
// rtl/mode7_affine_stream_pkg.sv - shared state, wrap-mode encodings and width helpers
package mode7_affine_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_MUL   = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  localparam logic [1:0] WRAP_REPEAT      = 2'd0;
  localparam logic [1:0] WRAP_CLAMP       = 2'd1;
  localparam logic [1:0] WRAP_TRANSPARENT = 2'd2;
  localparam logic [1:0] WRAP_RESERVED    = 2'd3;

  // Three guard bits keep the accumulator wide enough for rotated, offset coordinates
  function automatic int acc_width(input int coord_w, input int frac_w);
    return coord_w + frac_w + 3;
  endfunction

endpackage

// File: rtl/mode7_trig_lut.sv
// rtl/mode7_trig_lut.sv - registered quarter-wave sin/cos table, one cycle latency
module mode7_trig_lut #(
  parameter int ANGLE_W = 10,
  parameter int FRAC_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ANGLE_W-1:0]         angle,
  output logic signed [FRAC_W+1:0]   sin_val,
  output logic signed [FRAC_W+1:0]   cos_val
);

  localparam int QN = 2 ** (ANGLE_W - 2);
  localparam int EW = FRAC_W + 1;
  localparam int TW = FRAC_W + 2;

  // Table holds sin over [0, 90] degrees inclusive, QN+1 unsigned magnitudes
  function automatic logic [(QN+1)*EW-1:0] build_table();
    logic [(QN+1)*EW-1:0] t;
    real scale;
    real pi;
    int  val;
    t     = '0;
    pi    = 3.14159265358979323846;
    scale = 1.0;
    for (int k = 0; k < FRAC_W; k++) scale = scale * 2.0;
    for (int i = 0; i <= QN; i++) begin
      val = $rtoi($sin(pi * i / (2.0 * QN)) * scale + 0.5);
      t[i*EW +: EW] = EW'(val);
    end
    return t;
  endfunction

  localparam logic [(QN+1)*EW-1:0] QTAB = build_table();

  // Fold a full-circle angle onto the quarter table; quadrant bit 0 mirrors, bit 1 negates
  function automatic logic signed [TW-1:0] lookup(input logic [ANGLE_W-1:0] a);
    logic [1:0]         quad;
    logic [ANGLE_W-1:0] phase;
    logic [ANGLE_W-1:0] idx;
    logic [EW-1:0]      mag;
    quad  = a[ANGLE_W-1 -: 2];
    phase = {2'b00, a[ANGLE_W-3:0]};
    idx   = quad[0] ? (ANGLE_W'(QN) - phase) : phase;
    mag   = QTAB[idx*EW +: EW];
    return quad[1] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  logic [ANGLE_W-1:0] cos_angle;
  assign cos_angle = angle + ANGLE_W'(QN);

  // Register both lookups so the table read sits in its own pipeline stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sin_val <= '0;
      cos_val <= '0;
    end else begin
      sin_val <= lookup(angle);
      cos_val <= lookup(cos_angle);
    end
  end

endmodule

// File: rtl/mode7_affine_stream.sv
// rtl/mode7_affine_stream.sv - scanline Mode-7 affine texel address generator
module mode7_affine_stream
  import mode7_affine_stream_pkg::*;
#(
  parameter int COORD_W    = 16,
  parameter int FRAC_W     = 8,
  parameter int ANGLE_W    = 10,
  parameter int TEX_LOG2_W = 6,
  parameter int TEX_LOG2_H = 6
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [COORD_W-1:0]             cmd_x0,
  input  logic [COORD_W-1:0]             cmd_y,
  input  logic [COORD_W-1:0]             cmd_originx,
  input  logic [COORD_W-1:0]             cmd_originy,
  input  logic [COORD_W-1:0]             cmd_offsetx,
  input  logic [COORD_W-1:0]             cmd_offsety,
  input  logic [ANGLE_W-1:0]             cmd_angle,
  input  logic [COORD_W-1:0]             cmd_count,
  input  logic [1:0]                     cmd_wrap,
  input  logic                           abort,
  output logic                           pix_valid,
  input  logic                           pix_ready,
  output logic [TEX_LOG2_W-1:0]          pix_u,
  output logic [TEX_LOG2_H-1:0]          pix_v,
  output logic [TEX_LOG2_W+TEX_LOG2_H-1:0] pix_addr,
  output logic                           pix_oob,
  output logic                           pix_last
);

  localparam int ACC_W  = acc_width(COORD_W, FRAC_W);
  localparam int INT_W  = ACC_W - FRAC_W;
  localparam int TRIG_W = FRAC_W + 2;

  state_e state_q, state_d;

  logic [COORD_W-1:0] x0_q, y_q, originx_q, originy_q, offsetx_q, offsety_q;
  logic [COORD_W-1:0] count_q, remaining_q;
  logic [ANGLE_W-1:0] angle_q;
  logic [1:0]         wrap_q;

  logic signed [ACC_W-1:0]  u_acc, v_acc;
  logic signed [TRIG_W-1:0] cos_val, sin_val;

  mode7_trig_lut #(
    .ANGLE_W (ANGLE_W),
    .FRAC_W  (FRAC_W)
  ) u_trig (
    .clk     (clk),
    .rst_n   (rst_n),
    .angle   (angle_q),
    .sin_val (sin_val),
    .cos_val (cos_val)
  );

  logic signed [ACC_W-1:0] c_ext, s_ext, dx_ext, dy_ext, base_u, base_v, u_init, v_init;
  logic signed [COORD_W:0] dx, dy;
  logic [COORD_W:0]        sum_x, sum_y;

  assign c_ext  = {{(ACC_W-TRIG_W){cos_val[TRIG_W-1]}}, cos_val};
  assign s_ext  = {{(ACC_W-TRIG_W){sin_val[TRIG_W-1]}}, sin_val};
  assign dx     = $signed({1'b0, x0_q}) - $signed({1'b0, originx_q});
  assign dy     = $signed({1'b0, y_q})  - $signed({1'b0, originy_q});
  assign dx_ext = {{(ACC_W-COORD_W-1){dx[COORD_W]}}, dx};
  assign dy_ext = {{(ACC_W-COORD_W-1){dy[COORD_W]}}, dy};
  assign sum_x  = {1'b0, originx_q} + {1'b0, offsetx_q};
  assign sum_y  = {1'b0, originy_q} + {1'b0, offsety_q};
  assign base_u = {{(ACC_W-COORD_W-1){1'b0}}, sum_x} << FRAC_W;
  assign base_v = {{(ACC_W-COORD_W-1){1'b0}}, sum_y} << FRAC_W;
  assign u_init = c_ext * dx_ext - s_ext * dy_ext + base_u;
  assign v_init = s_ext * dx_ext + c_ext * dy_ext + base_v;

  logic handshake;
  assign handshake = (state_q == ST_RUN) && pix_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake outputs; abort overrides every transition
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    pix_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = ST_SETUP;
      end
      ST_SETUP: state_d = ST_MUL;
      ST_MUL:   state_d = (count_q == '0) ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        pix_valid = 1'b1;
        if (pix_ready && remaining_q == COORD_W'(1)) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // Command capture, accumulator seeding and per-pixel stepping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0_q        <= '0;
      y_q         <= '0;
      originx_q   <= '0;
      originy_q   <= '0;
      offsetx_q   <= '0;
      offsety_q   <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      angle_q     <= '0;
      wrap_q      <= WRAP_REPEAT;
      u_acc       <= '0;
      v_acc       <= '0;
    end else if (!abort) begin
      if (state_q == ST_IDLE && cmd_valid) begin
        x0_q      <= cmd_x0;
        y_q       <= cmd_y;
        originx_q <= cmd_originx;
        originy_q <= cmd_originy;
        offsetx_q <= cmd_offsetx;
        offsety_q <= cmd_offsety;
        count_q   <= cmd_count;
        angle_q   <= cmd_angle;
        wrap_q    <= cmd_wrap;
      end
      if (state_q == ST_MUL) begin
        u_acc       <= u_init;
        v_acc       <= v_init;
        remaining_q <= count_q;
      end
      if (handshake) begin
        u_acc       <= u_acc + c_ext;
        v_acc       <= v_acc + s_ext;
        remaining_q <= remaining_q - COORD_W'(1);
      end
    end
  end

  logic [INT_W-1:0] u_int, v_int;
  logic             u_oor, v_oor;
  assign u_int = u_acc[ACC_W-1:FRAC_W];
  assign v_int = v_acc[ACC_W-1:FRAC_W];
  assign u_oor = |u_int[INT_W-1:TEX_LOG2_W];
  assign v_oor = |v_int[INT_W-1:TEX_LOG2_H];

  // Per-axis wrap: clamp saturates, every other mode keeps the low bits
  always_comb begin
    pix_u = u_int[TEX_LOG2_W-1:0];
    pix_v = v_int[TEX_LOG2_H-1:0];
    case (wrap_q)
      WRAP_CLAMP: begin
        if (u_oor) pix_u = u_int[INT_W-1] ? '0 : '1;
        if (v_oor) pix_v = v_int[INT_W-1] ? '0 : '1;
      end
      WRAP_REPEAT, WRAP_TRANSPARENT, WRAP_RESERVED: ;
      default: ;
    endcase
  end

  assign pix_addr = {pix_v, pix_u};
  assign pix_oob  = pix_valid && (wrap_q == WRAP_TRANSPARENT) && (u_oor || v_oor);
  assign pix_last = pix_valid && (remaining_q == COORD_W'(1));

endmodule
